// File: rtl/wash_program_sequencer.sv
// Program controller for the washing FSM: latches the program, times wash/rinse/spin,
// issues timeout pulses and watches the fill/drain valves for stuck-on faults.
module wash_program_sequencer #(
    parameter int QUICK_TICKS  = 8,
    parameter int NORMAL_TICKS = 16,
    parameter int HEAVY_TICKS  = 32,
    parameter int RINSE_TICKS  = 10,
    parameter int SPIN_TICKS   = 12,
    parameter int FILL_LIMIT   = 64,
    parameter int DRAIN_LIMIT  = 64,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [1:0]       prog,
    input  logic             abort,
    input  logic             motor_on,
    input  logic             fill_valve_on,
    input  logic             drain_valve_on,
    input  logic             drained,
    input  logic             done,
    output logic             start,
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic             busy,
    output logic             fault,
    output logic             complete,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4,
        FAULT = 3'd5
    } phase_e;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] QUICK_LEN  = CNT_W'(QUICK_TICKS);
    localparam logic [CNT_W-1:0] NORMAL_LEN = CNT_W'(NORMAL_TICKS);
    localparam logic [CNT_W-1:0] HEAVY_LEN  = CNT_W'(HEAVY_TICKS);
    localparam logic [CNT_W-1:0] RINSE_LEN  = CNT_W'(RINSE_TICKS);
    localparam logic [CNT_W-1:0] SPIN_LEN   = CNT_W'(SPIN_TICKS);
    localparam logic [CNT_W-1:0] FILL_LIM   = CNT_W'(FILL_LIMIT);
    localparam logic [CNT_W-1:0] DRAIN_LIM  = CNT_W'(DRAIN_LIMIT);

    phase_e           state;
    logic [CNT_W-1:0] dur, tmr, fill_cnt, drain_cnt;
    logic             spin_flag;

    logic [CNT_W-1:0] fill_nxt, drain_nxt, tmr_inc;
    logic             wd_trip;

    // The drain valve is legitimately held through spin, so its watchdog stops once drained.
    assign fill_nxt  = fill_valve_on ? fill_cnt + ONE : '0;
    assign drain_nxt = (drain_valve_on && !spin_flag) ? drain_cnt + ONE : '0;
    assign wd_trip   = (fill_nxt == FILL_LIM) || (drain_nxt == DRAIN_LIM);
    assign tmr_inc   = tmr + ONE;
    assign phase     = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            dur           <= '0;
            tmr           <= '0;
            fill_cnt      <= '0;
            drain_cnt     <= '0;
            spin_flag     <= 1'b0;
            start         <= 1'b0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            busy          <= 1'b0;
            fault         <= 1'b0;
            complete      <= 1'b0;
            remaining     <= '0;
        end else begin
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
            complete      <= 1'b0;
            fill_cnt      <= fill_nxt;
            drain_cnt     <= drain_nxt;
            if (abort) begin
                state     <= IDLE;
                tmr       <= '0;
                spin_flag <= 1'b0;
                fill_cnt  <= '0;
                drain_cnt <= '0;
                start     <= 1'b0;
                busy      <= 1'b0;
                fault     <= 1'b0;
                remaining <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        fill_cnt  <= '0;
                        drain_cnt <= '0;
                        if (go && prog != 2'b11) begin
                            case (prog)
                                2'b00:   dur <= QUICK_LEN;
                                2'b01:   dur <= NORMAL_LEN;
                                default: dur <= HEAVY_LEN;
                            endcase
                            state <= ARM;
                            start <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                    FAULT: begin
                        fill_cnt  <= '0;
                        drain_cnt <= '0;
                    end
                    default: begin
                        // A watchdog trip overrides any timer expiry or done in the same cycle.
                        if (wd_trip) begin
                            state     <= FAULT;
                            fault     <= 1'b1;
                            busy      <= 1'b0;
                            start     <= 1'b0;
                            tmr       <= '0;
                            spin_flag <= 1'b0;
                            fill_cnt  <= '0;
                            drain_cnt <= '0;
                            remaining <= '0;
                        end else begin
                            case (state)
                                ARM: begin
                                    if (fill_valve_on) begin
                                        start     <= 1'b0;
                                        tmr       <= '0;
                                        state     <= WASH;
                                        remaining <= dur;
                                    end
                                end
                                WASH: begin
                                    if (motor_on) begin
                                        if (tmr_inc == dur) begin
                                            cycle_timeout <= 1'b1;
                                            tmr           <= '0;
                                            state         <= RINSE;
                                            remaining     <= RINSE_LEN;
                                        end else begin
                                            tmr       <= tmr_inc;
                                            remaining <= dur - tmr_inc;
                                        end
                                    end
                                end
                                RINSE: begin
                                    if (motor_on) begin
                                        if (tmr_inc == RINSE_LEN) begin
                                            cycle_timeout <= 1'b1;
                                            tmr           <= '0;
                                            spin_flag     <= 1'b0;
                                            state         <= SPIN;
                                            remaining     <= '0;
                                        end else begin
                                            tmr       <= tmr_inc;
                                            remaining <= RINSE_LEN - tmr_inc;
                                        end
                                    end
                                end
                                SPIN: begin
                                    if (!spin_flag) begin
                                        if (drained) begin
                                            spin_flag <= 1'b1;
                                            tmr       <= '0;
                                            remaining <= SPIN_LEN;
                                        end
                                    end else if (tmr != SPIN_LEN) begin
                                        tmr          <= tmr_inc;
                                        remaining    <= SPIN_LEN - tmr_inc;
                                        spin_timeout <= (tmr_inc == SPIN_LEN);
                                    end else if (done) begin
                                        complete  <= 1'b1;
                                        state     <= IDLE;
                                        busy      <= 1'b0;
                                        spin_flag <= 1'b0;
                                        tmr       <= '0;
                                        remaining <= '0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Randomized and directed bench for wash_program_sequencer against a phase-level reference model.
module tb_wash_program_sequencer;

    localparam int QT = 8, NT = 16, HT = 32, RT = 10, ST = 12, FL = 64, DL = 64, CW = 8;
    localparam int P_IDLE = 0, P_ARM = 1, P_WASH = 2, P_RINSE = 3, P_SPIN = 4, P_FAULT = 5;

    logic          clk = 1'b0;
    logic          reset, go, abort, motor_on, fill_valve_on, drain_valve_on, drained, done;
    logic [1:0]    prog;
    logic          start, cycle_timeout, spin_timeout, busy, fault, complete;
    logic [2:0]    phase;
    logic [CW-1:0] remaining;

    int n_chk = 0, n_fail = 0;
    int m_phase, m_dur, m_cnt, m_fill, m_drain;
    bit m_flag, m_cto, m_sto, m_cmp;

    always #5 clk = ~clk;

    wash_program_sequencer #(
        .QUICK_TICKS(QT), .NORMAL_TICKS(NT), .HEAVY_TICKS(HT), .RINSE_TICKS(RT),
        .SPIN_TICKS(ST), .FILL_LIMIT(FL), .DRAIN_LIMIT(DL), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .prog(prog), .abort(abort),
        .motor_on(motor_on), .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
        .drained(drained), .done(done), .start(start), .cycle_timeout(cycle_timeout),
        .spin_timeout(spin_timeout), .busy(busy), .fault(fault), .complete(complete),
        .phase(phase), .remaining(remaining)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_dur = 0; m_cnt = 0; m_fill = 0; m_drain = 0;
        m_flag = 0; m_cto = 0; m_sto = 0; m_cmp = 0;
    endtask

    function automatic int rem_exp();
        case (m_phase)
            P_WASH:  return m_dur - m_cnt;
            P_RINSE: return RT - m_cnt;
            P_SPIN:  return m_flag ? ST - m_cnt : 0;
            default: return 0;
        endcase
    endfunction

    // One clock of the program rules, applied to the inputs sampled at this edge.
    task automatic model_step();
        int fn, dn;
        m_cto = 0; m_sto = 0; m_cmp = 0;
        if (abort) begin
            model_reset();
            return;
        end
        case (m_phase)
            P_IDLE: begin
                m_fill = 0; m_drain = 0;
                if (go && prog != 2'b11) begin
                    m_phase = P_ARM;
                    m_dur = (prog == 2'b00) ? QT : (prog == 2'b01) ? NT : HT;
                end
            end
            P_FAULT: ;
            default: begin
                fn = fill_valve_on ? m_fill + 1 : 0;
                dn = (drain_valve_on && !m_flag) ? m_drain + 1 : 0;
                m_fill = fn; m_drain = dn;
                if (fn >= FL || dn >= DL) begin
                    m_phase = P_FAULT; m_cnt = 0; m_flag = 0; m_fill = 0; m_drain = 0;
                end else if (m_phase == P_ARM) begin
                    if (fill_valve_on) begin m_phase = P_WASH; m_cnt = 0; end
                end else if (m_phase == P_WASH || m_phase == P_RINSE) begin
                    if (motor_on) m_cnt++;
                    if (m_cnt == ((m_phase == P_WASH) ? m_dur : RT)) begin
                        m_cto = 1; m_cnt = 0; m_flag = 0; m_phase++;
                    end
                end else begin
                    if (!m_flag) begin
                        if (drained) begin m_flag = 1; m_cnt = 0; end
                    end else if (m_cnt < ST) begin
                        m_cnt++;
                        m_sto = (m_cnt == ST);
                    end else if (done) begin
                        m_cmp = 1; m_phase = P_IDLE; m_cnt = 0; m_flag = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic check_all();
        chk("start", start, m_phase == P_ARM);
        chk("cycle_timeout", cycle_timeout, m_cto);
        chk("spin_timeout", spin_timeout, m_sto);
        chk("busy", busy, m_phase >= P_ARM && m_phase <= P_SPIN);
        chk("fault", fault, m_phase == P_FAULT);
        chk("complete", complete, m_cmp);
        chk("phase", phase, m_phase);
        chk("remaining", remaining, rem_exp());
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        go = 0; prog = 2'b00; abort = 0; motor_on = 0; fill_valve_on = 0;
        drain_valve_on = 0; drained = 0; done = 0;
    endtask

    task automatic do_abort();
        clear_inputs();
        abort = 1; cyc(); abort = 0;
    endtask

    // Crude washing-FSM stand-in driving one full program from go to done.
    task automatic run_program(input logic [1:0] p, input int motor_pct);
        int guard;
        go = 1; prog = p; cyc(); go = 0;
        repeat ($urandom_range(1, 5)) begin prog = 2'($urandom_range(0, 3)); cyc(); end
        fill_valve_on = 1;
        repeat ($urandom_range(2, 10)) cyc();
        fill_valve_on = 0;
        guard = 0;
        while ((m_phase == P_WASH || m_phase == P_RINSE) && guard < 2000) begin
            motor_on       = ($urandom_range(0, 99) < motor_pct);
            fill_valve_on  = ($urandom_range(0, 3) == 0);
            drain_valve_on = ($urandom_range(0, 3) == 0);
            prog           = 2'($urandom_range(0, 3));
            cyc(); guard++;
        end
        chk("reach_spin", phase, P_SPIN);
        fill_valve_on = 0; motor_on = 1; drain_valve_on = 1; drained = 0;
        repeat ($urandom_range(0, 8)) cyc();
        drained = 1; guard = 0;
        while (!(m_flag && m_cnt == ST) && guard < 100) begin cyc(); guard++; end
        chk("spin_pulse", spin_timeout, 1);
        drain_valve_on = 0; motor_on = 0;
        repeat ($urandom_range(0, 3)) cyc();
        done = 1; cyc();
        chk("run_complete", complete, 1);
        chk("run_idle", phase, P_IDLE);
        clear_inputs(); cyc();
    endtask

    initial begin
        int guard;
        model_reset();
        clear_inputs();
        reset = 1;
        @(posedge clk); #1;
        check_all();
        #2 reset = 0;

        // Quick program: fill three clocks after go, then continuous motor.
        go = 1; prog = 2'b00; cyc(); go = 0;
        chk("arm_start", start, 1);
        repeat (2) cyc();
        fill_valve_on = 1; cyc(); fill_valve_on = 0;
        chk("wash_phase", phase, P_WASH);
        motor_on = 1;
        repeat (QT - 1) cyc();
        chk("wash_early_to", cycle_timeout, 0);
        cyc();
        chk("wash_to", cycle_timeout, 1);
        chk("rinse_phase", phase, P_RINSE);
        do_abort();

        run_program(2'b01, 100);
        run_program(2'b10, 50);
        run_program(2'b00, 70);

        // Fill valve stuck on.
        go = 1; prog = 2'b00; cyc(); go = 0;
        fill_valve_on = 1;
        repeat (FL + 6) cyc();
        chk("fill_fault", fault, 1);
        chk("fill_fault_phase", phase, P_FAULT);
        chk("fault_busy", busy, 0);
        do_abort();
        chk("fault_abort_phase", phase, P_IDLE);
        chk("fault_abort_flag", fault, 0);

        // Drain valve stuck on during wash.
        go = 1; prog = 2'b01; cyc(); go = 0;
        fill_valve_on = 1; cyc(); fill_valve_on = 0;
        drain_valve_on = 1;
        repeat (DL + 2) cyc();
        chk("drain_fault", fault, 1);
        do_abort();

        // Abort on the clock the wash timer expires.
        go = 1; prog = 2'b00; cyc(); go = 0;
        fill_valve_on = 1; cyc(); fill_valve_on = 0;
        motor_on = 1;
        repeat (QT - 1) cyc();
        abort = 1; cyc(); abort = 0; motor_on = 0;
        chk("abort_no_to", cycle_timeout, 0);
        chk("abort_idle", phase, P_IDLE);

        go = 1; prog = 2'b11; cyc(); go = 0;
        chk("prog11_idle", phase, P_IDLE);
        chk("prog11_start", start, 0);

        // Fill watchdog trips on the same clock the wash timer would expire.
        go = 1; prog = 2'b00; cyc(); go = 0;
        fill_valve_on = 1; cyc(); fill_valve_on = 0;
        motor_on = 1;
        repeat (QT - 1) cyc();
        motor_on = 0; fill_valve_on = 1; guard = 0;
        while (m_fill < FL - 1 && guard < 200) begin cyc(); guard++; end
        motor_on = 1; cyc();
        chk("fault_beats_to", cycle_timeout, 0);
        chk("fault_beats_phase", phase, P_FAULT);
        do_abort();

        // Asynchronous reset in the middle of rinse.
        go = 1; prog = 2'b00; cyc(); go = 0;
        fill_valve_on = 1; cyc(); fill_valve_on = 0;
        motor_on = 1; guard = 0;
        while (!(m_phase == P_RINSE && RT - m_cnt == 4) && guard < 100) begin cyc(); guard++; end
        chk("rem_before_reset", remaining, 4);
        motor_on = 0;
        #2 reset = 1;
        #1;
        model_reset();
        chk("rst_phase", phase, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        #3 reset = 0;
        run_program(2'b00, 80);

        // Unconstrained input soup.
        for (int i = 0; i < 600; i++) begin
            go             = ($urandom_range(0, 9) == 0);
            prog           = 2'($urandom_range(0, 3));
            abort          = ($urandom_range(0, 49) == 0);
            motor_on       = ($urandom_range(0, 9) < 7);
            fill_valve_on  = ($urandom_range(0, 1) == 0);
            drain_valve_on = ($urandom_range(0, 1) == 0);
            drained        = ($urandom_range(0, 9) < 3);
            done           = ($urandom_range(0, 9) < 3);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_program_sequencer.md
Name: wash_program_sequencer

Overview:
- Program controller for the washing-machine FSM. It latches a user-selected wash program and asserts the FSM's start.
- It times the soap-wash, rinse and spin phases, then issues single-cycle cycle_timeout and spin_timeout pulses to the FSM.
- It runs fill/drain watchdogs on the FSM's valve outputs and reports progress and faults to the front panel.

Parameters:
- QUICK_TICKS, 8, soap-wash motor ticks for prog 00
- NORMAL_TICKS, 16, soap-wash motor ticks for prog 01
- HEAVY_TICKS, 32, soap-wash motor ticks for prog 10
- RINSE_TICKS, 10, rinse motor ticks, all programs
- SPIN_TICKS, 12, spin ticks counted after drained
- FILL_LIMIT, 64, max consecutive fill_valve_on cycles before fault
- DRAIN_LIMIT, 64, max consecutive drain_valve_on cycles before fault
- CNT_W, 8, width of all timers and of remaining

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- go  in  1  user start request, sampled in IDLE only
- prog  in  2  program select: 00 quick, 01 normal, 10 heavy, 11 invalid
- abort  in  1  user abort, highest functional priority
- motor_on  in  1  from washing FSM
- fill_valve_on  in  1  from washing FSM
- drain_valve_on  in  1  from washing FSM
- drained  in  1  drain sensor, shared with FSM
- done  in  1  from washing FSM
- start  out  1  to FSM start
- cycle_timeout  out  1  to FSM, one-clock pulse
- spin_timeout  out  1  to FSM, one-clock pulse
- busy  out  1  high in every phase except IDLE and FAULT
- fault  out  1  high in FAULT
- complete  out  1  one-clock pulse when a run finishes
- phase  out  3  0 IDLE, 1 ARM, 2 WASH, 3 RINSE, 4 SPIN, 5 FAULT
- remaining  out  CNT_W  ticks left in the current timed phase, else 0

Behaviour:
- Reset (asynchronous, active-high): phase=IDLE; all timers and watchdogs 0; every output 0.
- All outputs are registered.

IDLE:
- go=1 with prog!=11: latch wash duration from prog; go to ARM.
- go=1 with prog=11: ignored, stay IDLE.

ARM:
- start=1 held.
- On fill_valve_on=1 sampled: start=0, clear wash timer, go to WASH.
- No timeout in ARM; only abort leaves it.

WASH:
- Timer increments on each edge sampling motor_on=1. It holds while motor_on=0, covering fill and detergent time.
- When the count reaches the latched duration: cycle_timeout=1 for exactly the next clock; clear timer; go to RINSE.

RINSE:
- Same timing with RINSE_TICKS.
- On expiry: cycle_timeout pulse; go to SPIN.
- The FSM's intermediate drain/refill between the two cycles needs no action beyond the watchdogs.

SPIN:
- Sticky flag set on first drained=1 sampled.
- With the flag set, the timer increments every clock.
- At SPIN_TICKS: spin_timeout=1 for one clock; wait for done.
- On done=1: complete pulse; go to IDLE.

Watchdogs:
- Fill counter: consecutive cycles with fill_valve_on=1; cleared when it is 0.
- Drain counter: consecutive cycles with drain_valve_on=1; cleared when it is 0. Disabled once the SPIN drained flag is set, because the FSM holds the drain valve during spin.
- Either counter reaching its limit: go to FAULT.

FAULT:
- start, timeouts and busy = 0; fault=1.
- Left only by abort (to IDLE) or reset.

remaining:
- In WASH, RINSE and SPIN (flag set): duration minus count.
- Otherwise 0.

Priorities and corner cases:
- abort in any phase: IDLE next clock; timers cleared; no pulses issued.
- abort beats a fault, a timeout and done arriving in the same cycle.
- Fault detected in the same cycle as a timer expiry: fault wins, no timeout pulse.
- go while busy: ignored.
- prog changes mid-run: no effect; the duration is latched.
- Reset mid-run: immediate return to reset values.

Test Plan:
- prog=00, go; FSM model raises fill_valve_on 3 clk later, then motor_on continuously → start high until fill seen; phase 2; cycle_timeout high on exactly the clock after 8 motor_on edges; phase 3.
- Full normal run (prog=01) → cycle_timeout pulses after 16 and 10 motor_on ticks; spin_timeout 12 clk after drained; done → complete pulse; phase 0; busy low.
- fill_valve_on stuck high 64 clk → fault=1, phase 5; start, timeouts and busy remain 0; abort → phase 0, fault=0.
- motor_on toggling 1/0 in WASH with prog=10 → timeout only after 32 high samples; remaining decrements only on high samples.
- abort on the same clock the wash timer expires → no cycle_timeout pulse, phase 0; prog=11 with go → stays IDLE.
- Reset asserted mid-RINSE with remaining=4 → all outputs 0 asynchronously; after release, go restarts cleanly from ARM.
